pointwise_conv_accum: RTL and testbench
=======================================

POINTWISE_CONV_ACCUM -- requirements
Module: pointwise_conv_accum

Interface
REQ-001 SHALL have parameter N, default 16, signed fixed-point data/weight width.
REQ-002 SHALL have parameter Q, default 8, fractional bits.
REQ-003 SHALL have parameter IN_CHANNELS, default 4, input channels per pixel (>=2).
REQ-004 SHALL have parameter OUT_CHANNELS, default 4, output channels per pixel (>=2).
REQ-005 SHALL have parameter PIXELS, default 64, pixels per frame.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-007 SHALL have ports: en in 1 frame start/run enable; act_mode in 2 activation select (0 none, 1 ReLU, 2 ReLU6, 3 reserved = none).
REQ-008 SHALL have ports: w_wr in 1 weight write strobe; w_addr in clog2(IN_CHANNELS*OUT_CHANNELS) index oc*IN_CHANNELS+ic; w_data in N weight.
REQ-009 SHALL have ports: in_valid in 1; in_ready out 1; in_data in N; input channel order implicit, 0..IN_CHANNELS-1 per pixel.
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; out_data out N; out_channel out clog2(OUT_CHANNELS); out_last out 1 (last channel of last pixel); done out 1 (one-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, LOAD, COMPUTE, EMIT, DONE.
REQ-012 IDLE: w_wr writes weight_mem[w_addr]<=w_data; w_wr outside IDLE SHALL be ignored.
REQ-013 IDLE->LOAD when en=1; pixel counter and channel counters cleared.
REQ-014 LOAD: in_ready=1 only while en=1; each in_valid&in_ready beat stores in_data to pixel buffer[ic], ic++; after beat ic=IN_CHANNELS-1 -> COMPUTE, oc=0.
REQ-015 COMPUTE: one MAC per cycle, acc += in_buf[ic]*weight_mem[oc*IN_CHANNELS+ic], signed, acc width 2N+clog2(IN_CHANNELS), no overflow; exactly IN_CHANNELS cycles, acc cleared at entry; then -> EMIT.
REQ-016 Requantise on COMPUTE->EMIT: r = (acc + 2^(Q-1)) >>> Q (arithmetic), saturate to [-2^(N-1), 2^(N-1)-1].
REQ-017 Activation after saturation: mode 1 clamps negatives to 0; mode 2 clamps to [0, 6*2^Q] (also saturated to N bits); act_mode sampled at IDLE->LOAD and held for frame.
REQ-018 EMIT: out_valid=1, out_data/out_channel/out_last stable until out_valid&out_ready.
REQ-019 On EMIT handshake: oc<OUT_CHANNELS-1 -> oc++, COMPUTE; else pixel<PIXELS-1 -> pixel++, LOAD; else -> DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 en=0 in LOAD/COMPUTE SHALL freeze state and counters (in_ready=0); en=0 in EMIT SHALL hold outputs, handshake still honoured.
REQ-022 Latency: last input beat to first out_valid = IN_CHANNELS+1 cycles; back-to-back out_ready=1 gives one output per IN_CHANNELS+1 cycles.
REQ-023 out_last=1 only with oc=OUT_CHANNELS-1 and pixel=PIXELS-1.

Reset
REQ-024 rst SHALL force IDLE, counters 0, acc 0, in_ready 0, out_valid 0, out_data 0, out_channel 0, out_last 0, done 0, from any state including mid-frame.
REQ-025 rst SHALL clear all weight_mem entries to 0; pixel buffer contents need not be cleared.

Verification
REQ-026 Identity: weights 0x0100 where ic==oc else 0, act_mode 0, pixel in {0x0100,0x0200,0x0300,0x0400} -> outputs 0x0100,0x0200,0x0300,0x0400, channels 0..3, out_last on pixel 63 ch 3, done one cycle later.
REQ-027 Sum/saturation: all weights 0x7FFF, inputs 0x7FFF -> every out_data 0x7FFF; inputs 0x8000, weights 0x7FFF -> 0x8000.
REQ-028 Activation: weights identity, input 0xFE00 with mode 1 -> 0x0000; input 0x0800 with mode 2 -> 0x0600; rounding check input 0x0001, weight 0x0080 -> 0x0001.
REQ-029 Backpressure: out_ready held 0 for 10 cycles in EMIT -> out_data stable, no in_ready, no counter advance; release -> sequence resumes unchanged.
REQ-030 Reset mid-frame: rst during COMPUTE of pixel 5 -> next cycle all outputs at reset values, weights 0; new frame after reload matches REQ-026.
REQ-031 Weight-write guard: w_wr during LOAD with w_data 0x7FFF -> outputs unchanged versus no-write run.

Source files
------------

// File: rtl/pointwise_conv_accum.sv
// pointwise_conv_accum: 1x1 (pointwise) convolution engine.
// Each pixel arrives as IN_CHANNELS serial samples. For every output channel the
// engine runs IN_CHANNELS multiply-accumulates (one per cycle). It then rounds
// and saturates the sum back to N-bit Q-format, applies an optional ReLU/ReLU6,
// and presents the result on a valid/ready output port.
module pointwise_conv_accum #(
  parameter int N            = 16,
  parameter int Q            = 8,
  parameter int IN_CHANNELS  = 4,
  parameter int OUT_CHANNELS = 4,
  parameter int PIXELS       = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        en,
  input  logic [1:0]                                  act_mode,
  input  logic                                        w_wr,
  input  logic [$clog2(IN_CHANNELS*OUT_CHANNELS)-1:0] w_addr,
  input  logic [N-1:0]                                w_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [N-1:0]                                in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [N-1:0]                                out_data,
  output logic [$clog2(OUT_CHANNELS)-1:0]             out_channel,
  output logic                                        out_last,
  output logic                                        done
);

  localparam int WN  = IN_CHANNELS * OUT_CHANNELS;
  localparam int WAW = $clog2(WN);
  localparam int ICW = $clog2(IN_CHANNELS);
  localparam int OCW = $clog2(OUT_CHANNELS);
  localparam int PW  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int MW  = 2 * N;
  localparam int AW  = 2 * N + $clog2(IN_CHANNELS);

  localparam logic [ICW-1:0] IC_LAST  = ICW'(IN_CHANNELS - 1);
  localparam logic [OCW-1:0] OC_LAST  = OCW'(OUT_CHANNELS - 1);
  localparam logic [PW-1:0]  PIX_LAST = PW'(PIXELS - 1);

  // Round-half-up constant and the N-bit signed range expressed at accumulator width
  localparam logic signed [AW-1:0] RND   = AW'(1) <<< (Q - 1);
  localparam logic signed [AW-1:0] MAXV  = (AW'(1) <<< (N - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV  = ~MAXV;
  // ReLU6 ceiling (6.0 in Q format), clipped if 6.0 is not representable in N bits
  localparam logic signed [AW-1:0] SIX_W = AW'(6) <<< Q;
  localparam logic signed [N-1:0]  SIX   = (SIX_W > MAXV) ? MAXV[N-1:0] : SIX_W[N-1:0];

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, EMIT, DONE} state_t;

  state_t                state;
  logic [ICW-1:0]        ic;
  logic [OCW-1:0]        oc;
  logic [PW-1:0]         pixel;
  logic [1:0]            act_sel;
  logic signed [AW-1:0]  acc;

  logic signed [N-1:0]   weight_mem [WN];
  logic signed [N-1:0]   in_buf     [IN_CHANNELS];

  logic [WAW-1:0]        w_idx;
  logic signed [MW-1:0]  prod_p0;
  logic signed [AW-1:0]  acc_sum;

  // Round to nearest (half up), drop the Q fraction bits, clamp to N bits
  function automatic logic signed [N-1:0] requant(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + RND) >>> Q;
    if (r > MAXV)
      return MAXV[N-1:0];
    else if (r < MINV)
      return MINV[N-1:0];
    else
      return r[N-1:0];
  endfunction

  // Activation on the already-saturated value; mode 3 behaves as mode 0
  function automatic logic signed [N-1:0] activate(input logic signed [N-1:0] v,
                                                    input logic [1:0]          m);
    logic signed [N-1:0] r;
    r = v;
    case (m)
      2'd1: if (v < 0) r = '0;
      2'd2: begin
        if (v < 0)
          r = '0;
        else if (v > SIX)
          r = SIX;
      end
      default: r = v;
    endcase
    return r;
  endfunction

  // MAC datapath: weight index oc*IN_CHANNELS+ic, full-precision product and running sum
  assign w_idx   = WAW'(oc) * WAW'(IN_CHANNELS) + WAW'(ic);
  assign prod_p0 = MW'(in_buf[ic]) * MW'(weight_mem[w_idx]);
  assign acc_sum = acc + AW'(prod_p0);

  assign in_ready  = (state == LOAD) && en;
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);

  // Weight store: cleared on reset, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WN; i++)
        weight_mem[i] <= '0;
    end else if (state == IDLE && w_wr) begin
      weight_mem[w_addr] <= w_data;
    end
  end

  // Pixel buffer: captures one sample per accepted input beat, no reset needed
  always_ff @(posedge clk) begin
    if (state == LOAD && en && in_valid)
      in_buf[ic] <= in_data;
  end

  // Frame sequencer: load pixel, MAC each output channel, emit, repeat per pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ic          <= '0;
      oc          <= '0;
      pixel       <= '0;
      act_sel     <= '0;
      acc         <= '0;
      out_data    <= '0;
      out_channel <= '0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state    <= LOAD;
            ic       <= '0;
            oc       <= '0;
            pixel    <= '0;
            act_sel  <= act_mode;
            out_last <= 1'b0;
          end
        end

        LOAD: begin
          if (en && in_valid) begin
            if (ic == IC_LAST) begin
              state <= COMPUTE;
              ic    <= '0;
              oc    <= '0;
              acc   <= '0;
            end else begin
              ic <= ic + 1'b1;
            end
          end
        end

        COMPUTE: begin
          if (en) begin
            if (ic == IC_LAST) begin
              // Last product folds straight into the requantised output register
              state       <= EMIT;
              ic          <= '0;
              acc         <= '0;
              out_data    <= activate(requant(acc_sum), act_sel);
              out_channel <= oc;
              out_last    <= (oc == OC_LAST) && (pixel == PIX_LAST);
            end else begin
              acc <= acc_sum;
              ic  <= ic + 1'b1;
            end
          end
        end

        EMIT: begin
          if (out_ready) begin
            if (oc != OC_LAST) begin
              oc    <= oc + 1'b1;
              state <= COMPUTE;
            end else if (pixel != PIX_LAST) begin
              pixel <= pixel + 1'b1;
              oc    <= '0;
              state <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pointwise_conv_accum.sv
// tb_pointwise_conv_accum: randomized frame-level bench for pointwise_conv_accum
// with an arithmetic reference model of the 1x1 convolution.
module tb_pointwise_conv_accum;

  localparam int N     = 16;
  localparam int Q     = 8;
  localparam int IC    = 4;
  localparam int OC    = 4;
  localparam int PIX   = 64;
  localparam int TOTAL = PIX * OC;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   act_mode;
  logic         w_wr;
  logic [3:0]   w_addr;
  logic [N-1:0] w_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   out_channel;
  logic         out_last;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic signed [N-1:0] pix [PIX][IC];
  logic signed [N-1:0] wts [IC*OC];

  always #5 clk = ~clk;

  pointwise_conv_accum #(
    .N(N), .Q(Q), .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .PIXELS(PIX)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .act_mode(act_mode),
    .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_channel(out_channel), .out_last(out_last), .done(done)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product, round half up, saturate, activate
  function automatic longint model(input int p, input int o, input int mode);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < IC; i++)
      acc += longint'(pix[p][i]) * longint'(wts[o*IC+i]);
    r = (acc + (longint'(1) << (Q - 1))) >>> Q;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (mode == 1 && r < 0) r = 0;
    if (mode == 2) begin
      if (r < 0) r = 0;
      if (r > 6 * 256) r = 6 * 256;
    end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_channel"}, out_channel, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic set_identity(input logic signed [N-1:0] v);
    for (int o = 0; o < OC; o++)
      for (int i = 0; i < IC; i++)
        wts[o*IC+i] = (i == o) ? v : '0;
  endtask

  task automatic load_weights();
    for (int a = 0; a < IC*OC; a++) begin
      @(negedge clk);
      w_wr   = 1'b1;
      w_addr = a[3:0];
      w_data = wts[a];
    end
    @(negedge clk);
    w_wr = 1'b0;
  endtask

  // Runs one frame; rnd randomizes en/in_valid/out_ready, bp_at stalls that output
  // for 10 cycles, abort_px stops right after pixel abort_px is fully loaded,
  // wr_guard drives weight writes while busy, timing checks latency/throughput.
  task automatic run_frame(input int mode, input bit rnd, input int bp_at,
                           input int abort_px, input bit wr_guard, input bit timing);
    int in_ptr    = 0;
    int out_idx   = 0;
    int cyc       = 0;
    int stall     = 0;
    int last_beat = -1;
    int last_hs   = -1;
    bit aborted   = 1'b0;
    while (out_idx < TOTAL && cyc < 30000 && !aborted) begin
      @(negedge clk);
      en       = (cyc == 0 || !rnd) ? 1'b1 : ($urandom_range(0, 5) != 0);
      act_mode = (cyc == 0) ? 2'(mode) : 2'($urandom);
      in_valid = (in_ptr < PIX*IC) && (!rnd || $urandom_range(0, 2) != 0);
      if (in_ptr < PIX*IC)
        in_data = pix[in_ptr/IC][in_ptr%IC];
      if (bp_at == out_idx && out_valid && stall < 10) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      w_wr   = wr_guard && (cyc > 0);
      w_addr = 4'($urandom);
      w_data = 16'h7FFF;
      #1;
      if (in_valid && in_ready) begin
        in_ptr++;
        if (in_ptr % IC == 0) last_beat = cyc;
        if (abort_px >= 0 && in_ptr == (abort_px + 1) * IC) aborted = 1'b1;
      end
      if (out_valid) begin
        int p = out_idx / OC;
        int o = out_idx % OC;
        logic signed [63:0] e;
        e = model(p, o, mode);
        if (out_ready) begin
          check("data", $signed(out_data), e);
          check("chan", out_channel, o);
          check("last", out_last, (out_idx == TOTAL - 1));
          if (timing) begin
            if (o == 0) check("latency", cyc - last_beat, IC + 1);
            else        check("throughput", cyc - last_hs, IC + 1);
          end
          last_hs = cyc;
          out_idx++;
        end else begin
          check("hold_data", $signed(out_data), e);
          check("hold_in_ready", in_ready, 0);
        end
      end
      cyc++;
    end
    w_wr = 1'b0;
    if (!aborted) begin
      check("frame_outputs", out_idx, TOTAL);
      en       = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("done_pulse", done, 1);
      check("done_no_valid", out_valid, 0);
      @(negedge clk);
      check("done_single", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; act_mode = '0; w_wr = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Identity weights: outputs reproduce inputs
    set_identity(16'sh0100);
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = 16'((i + 1) * 256);
    load_weights();
    run_frame(0, 1'b0, -1, -1, 1'b0, 1'b1);

    // Saturation in both directions
    for (int a = 0; a < IC*OC; a++) wts[a] = 16'sh7FFF;
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = (p % 2 == 0) ? 16'sh7FFF : 16'sh8000;
    load_weights();
    run_frame(0, 1'b0, -1, -1, 1'b0, 1'b1);

    // ReLU with negative inputs
    set_identity(16'sh0100);
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = ($urandom_range(0, 1) != 0) ? 16'shFE00 : 16'($urandom);
    load_weights();
    run_frame(1, 1'b1, -1, -1, 1'b0, 1'b0);

    // ReLU6 ceiling
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = ($urandom_range(0, 1) != 0) ? 16'sh0800 : 16'($urandom);
    run_frame(2, 1'b0, -1, -1, 1'b0, 1'b0);

    // Rounding: 0x0001 * 0x0080 rounds up to 0x0001
    set_identity(16'sh0080);
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = ($urandom_range(0, 1) != 0) ? 16'sh0001 : 16'($urandom);
    load_weights();
    run_frame(0, 1'b0, -1, -1, 1'b0, 1'b0);

    // Random data with a 10-cycle output stall, then fully randomized frames
    for (int a = 0; a < IC*OC; a++) wts[a] = $signed(16'($urandom)) >>> $urandom_range(0, 8);
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = 16'($urandom);
    load_weights();
    run_frame(0, 1'b0, 37, -1, 1'b0, 1'b0);
    run_frame(3, 1'b1, -1, -1, 1'b0, 1'b0);
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = $signed(16'($urandom)) >>> $urandom_range(0, 6);
    run_frame(int'($urandom_range(0, 3)), 1'b1, 5, -1, 1'b0, 1'b0);

    // Weight writes outside IDLE must not take effect
    run_frame(0, 1'b1, -1, -1, 1'b1, 1'b0);

    // Reset while computing pixel 5
    set_identity(16'sh0100);
    for (int p = 0; p < PIX; p++)
      for (int i = 0; i < IC; i++)
        pix[p][i] = 16'((i + 1) * 256);
    load_weights();
    run_frame(0, 1'b0, -1, 5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;

    // Weights were cleared by reset: every output is zero
    for (int a = 0; a < IC*OC; a++) wts[a] = '0;
    run_frame(0, 1'b1, -1, -1, 1'b0, 1'b0);

    // Reload identity and repeat the identity frame
    set_identity(16'sh0100);
    load_weights();
    run_frame(0, 1'b0, -1, -1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
